// File: rtl/ln_stats_pkg.sv
// Shared types and width helpers for the streaming LayerNorm statistics unit.
// Widths are chosen so that sum, sum of squares and the variance numerator can never overflow.
package ln_stats_pkg;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        SQR = 2'd1,
        FIN = 2'd2,
        OUT = 2'd3
    } state_e;

    localparam int DIM_DEF    = 128;
    localparam int LANES_DEF  = 8;
    localparam int DATA_W_DEF = 16;
    localparam int BEATS_DEF  = DIM_DEF / LANES_DEF;
    localparam int CNT_W_DEF  = (BEATS_DEF > 1) ? $clog2(BEATS_DEF) : 1;

    function automatic int sum_w(input int dim, input int data_w);
        return data_w + $clog2(dim);
    endfunction

    function automatic int sq_w(input int dim, input int data_w);
        return 2 * data_w + $clog2(dim);
    endfunction

    function automatic int num_w(input int dim, input int data_w);
        return 2 * data_w + 2 * $clog2(dim) + 1;
    endfunction

    // A single-beat vector still needs a 1-bit counter.
    function automatic int cnt_w(input int dim, input int lanes);
        return ((dim / lanes) > 1) ? $clog2(dim / lanes) : 1;
    endfunction

endpackage

// File: rtl/ln_lane_reduce.sv
// Combinational reduction of one input beat: signed lane sum and unsigned sum of squares.
module ln_lane_reduce #(
    parameter int LANES  = 8,
    parameter int DATA_W = 16
) (
    input  logic [LANES*DATA_W-1:0]             data_i,
    output logic signed [DATA_W+$clog2(LANES)-1:0] lane_sum_o,
    output logic [2*DATA_W+$clog2(LANES)-1:0]   lane_sumsq_o
);

    localparam int LS_W = DATA_W + $clog2(LANES);
    localparam int LQ_W = 2 * DATA_W + $clog2(LANES);

    logic signed [DATA_W-1:0] elem [LANES];
    logic [2*DATA_W-1:0]      sq   [LANES];

    // A signed square is never negative, so it is carried as unsigned from here on.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign elem[gi] = data_i[gi*DATA_W +: DATA_W];
        assign sq[gi]   = elem[gi] * elem[gi];
    end

    always_comb begin
        lane_sum_o   = '0;
        lane_sumsq_o = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_o   = lane_sum_o + LS_W'(elem[i]);
            lane_sumsq_o = lane_sumsq_o + LQ_W'(sq[i]);
        end
    end

endmodule

// File: rtl/ln_stats_stream.sv
// Streaming LayerNorm statistics: accumulates one DIM-element vector in LANES-wide beats,
// then emits floor mean and exact population variance on a backpressured result stream.
module ln_stats_stream
    import ln_stats_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_mean,
    output logic [2*DATA_W-1:0]     out_var,
    output logic                    out_err
);

    localparam int LOG2_DIM = $clog2(DIM);
    localparam int BEATS    = DIM / LANES;
    localparam int CNT_W    = cnt_w(DIM, LANES);
    localparam int SUM_W    = sum_w(DIM, DATA_W);
    localparam int SQ_W     = sq_w(DIM, DATA_W);
    localparam int NUM_W    = num_w(DIM, DATA_W);
    localparam int VAR_W    = 2 * DATA_W;
    localparam int LS_W     = DATA_W + $clog2(LANES);
    localparam int LQ_W     = 2 * DATA_W + $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [SQ_W-1:0]         sumsq_q, sumsq_d;
    logic                    err_q, err_d;
    logic signed [NUM_W-1:0] sq_q, sq_d;
    logic signed [NUM_W-1:0] dimsq_q, dimsq_d;
    logic signed [NUM_W-1:0] num;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       out_mean_q, out_mean_d;
    logic [VAR_W-1:0]        out_var_q, out_var_d;
    logic                    out_err_q, out_err_d;

    logic signed [LS_W-1:0]  lane_sum;
    logic [LQ_W-1:0]         lane_sumsq;
    logic                    in_fire;
    logic                    last_beat;

    ln_lane_reduce #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_lane_reduce (
        .data_i       (in_data),
        .lane_sum_o   (lane_sum),
        .lane_sumsq_o (lane_sumsq)
    );

    assign in_fire   = in_valid && in_ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (in_fire && last_beat) state_d = SQR;
            SQR:     state_d = FIN;
            FIN:     state_d = OUT;
            OUT:     if (out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        in_ready = rst_n && (state_q == ACC);
    end

    // The beat counter alone decides the vector boundary; in_last only feeds the error flag.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        sum_d       = sum_q;
        sumsq_d     = sumsq_q;
        err_d       = err_q;
        sq_d        = sq_q;
        dimsq_d     = dimsq_q;
        out_valid_d = out_valid_q;
        out_mean_d  = out_mean_q;
        out_var_d   = out_var_q;
        out_err_d   = out_err_q;
        num         = dimsq_q - sq_q;
        case (state_q)
            ACC: begin
                if (in_fire) begin
                    beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
                    sum_d      = ((beat_cnt_q == '0) ? '0 : sum_q) + SUM_W'(lane_sum);
                    sumsq_d    = ((beat_cnt_q == '0) ? '0 : sumsq_q) + SQ_W'(lane_sumsq);
                    err_d      = err_q | (in_last != last_beat);
                end
            end
            SQR: begin
                sq_d    = NUM_W'(sum_q) * NUM_W'(sum_q);
                dimsq_d = NUM_W'(sumsq_q) << LOG2_DIM;
            end
            FIN: begin
                out_var_d   = VAR_W'(num >> (2 * LOG2_DIM));
                out_mean_d  = DATA_W'(sum_q >>> LOG2_DIM);
                out_err_d   = err_q;
                out_valid_d = 1'b1;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            sum_q       <= '0;
            sumsq_q     <= '0;
            err_q       <= 1'b0;
            sq_q        <= '0;
            dimsq_q     <= '0;
            out_valid_q <= 1'b0;
            out_mean_q  <= '0;
            out_var_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            sum_q       <= sum_d;
            sumsq_q     <= sumsq_d;
            err_q       <= err_d;
            sq_q        <= sq_d;
            dimsq_q     <= dimsq_d;
            out_valid_q <= out_valid_d;
            out_mean_q  <= out_mean_d;
            out_var_q   <= out_var_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mean  = out_mean_q;
    assign out_var   = out_var_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ln_stats_stream.sv
// Directed bench for ln_stats_stream with hand-computed mean/variance expectations.
module tb_ln_stats_stream;

    localparam int DIM    = 128;
    localparam int LANES  = 8;
    localparam int DATA_W = 16;
    localparam int BEATS  = DIM / LANES;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_mean;
    logic [2*DATA_W-1:0]     out_var;
    logic                    out_err;

    int n_cmp = 0;
    int n_bad = 0;
    int vec [DIM];

    always #5 clk = ~clk;

    ln_stats_stream #(
        .DIM    (DIM),
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mean  (out_mean),
        .out_var   (out_var),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 0: all 5, 1: +3/-3, 2: ramp 0..127, 3: 64 x -32768 then 64 x 32767, 4: all -32768
    task automatic fill(input int mode);
        for (int i = 0; i < DIM; i++) begin
            case (mode)
                0:       vec[i] = 5;
                1:       vec[i] = (i % 2 == 0) ? 3 : -3;
                2:       vec[i] = i;
                3:       vec[i] = (i < 64) ? -32768 : 32767;
                default: vec[i] = -32768;
            endcase
        end
    endtask

    // Entered and left just after a falling edge; the beat is taken at the rising edge in between.
    task automatic send_beat(input int b, input bit last);
        bit ok;
        for (int l = 0; l < LANES; l++) in_data[l*DATA_W +: DATA_W] = 16'(vec[b*LANES+l]);
        in_valid = 1'b1;
        in_last  = last;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            ok = in_ready;
            @(negedge clk);
        end
        chk("beat_accept", 64'(ok), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vector(input bit gaps, input bit early_last);
        for (int b = 0; b < BEATS; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_beat(b, early_last ? (b == 7) : (b == BEATS - 1));
        end
    endtask

    task automatic expect_result(input string tag, input int m, input longint v, input bit e, input int hold);
        logic [15:0] em;
        int w;
        em = 16'(m);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_mean"}, 64'(out_mean), 64'(em));
        chk({tag, "_var"}, 64'(out_var), 64'(v));
        chk({tag, "_err"}, 64'(out_err), 64'(e));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_mean"}, 64'(out_mean), 64'(em));
            chk({tag, "_hold_var"}, 64'(out_var), 64'(v));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_drain_inrdy"}, 64'(in_ready), 64'd1);
        $display("vector %s: mean=%0d var=%0d err=%0d", tag, $signed(out_mean), out_var, out_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_mean", 64'(out_mean), 64'd0);
        chk("rst_out_var", 64'(out_var), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // All fives, including exact result latency.
        fill(0);
        send_vector(1'b0, 1'b0);
        chk("lat_0", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_2", 64'(out_valid), 64'd1);
        expect_result("fives", 5, 0, 1'b0, 0);

        fill(1);
        send_vector(1'b0, 1'b0);
        expect_result("alt3", 0, 9, 1'b0, 0);

        fill(2);
        send_vector(1'b0, 1'b0);
        expect_result("ramp", 63, 1365, 1'b0, 0);

        // Extremes, with the result held under backpressure for 10 cycles.
        fill(3);
        send_vector(1'b0, 1'b0);
        expect_result("extremes_bp", -1, 1073709056, 1'b0, 10);

        fill(4);
        send_vector(1'b0, 1'b0);
        expect_result("all_min", -32768, 0, 1'b0, 0);

        fill(2);
        send_vector(1'b1, 1'b0);
        expect_result("ramp_gaps", 63, 1365, 1'b0, 0);

        // Back-to-back vectors: no carry-over of sum between them.
        fill(1);
        send_vector(1'b0, 1'b0);
        expect_result("b2b_a", 0, 9, 1'b0, 0);
        fill(0);
        send_vector(1'b0, 1'b0);
        expect_result("b2b_b", 5, 0, 1'b0, 0);

        // Early in_last: vector still spans 16 beats, error flagged once then cleared.
        fill(2);
        send_vector(1'b0, 1'b1);
        expect_result("early_last", 63, 1365, 1'b1, 0);
        fill(0);
        send_vector(1'b0, 1'b0);
        expect_result("after_err", 5, 0, 1'b0, 0);

        // Reset in the middle of a vector discards the partial accumulation.
        fill(2);
        for (int b = 0; b < 9; b++) send_beat(b, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_idle_valid", 64'(out_valid), 64'd0);
        fill(1);
        send_vector(1'b0, 1'b0);
        expect_result("after_rst", 0, 9, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ln_stats_stream.md
Name: ln_stats_stream

Overview:
Streaming LayerNorm statistics unit, the integer-mode successor to the fixed 128-wide fp16 variance block in the SFU.
- Accepts one DIM-element signed vector as DIM/LANES beats over a valid/ready stream.
- Computes the exact mean and population variance itself; no external E^2 input is needed.
- Presents the results on a backpressured output stream; the downstream rsqrt/gamma stage consumes them.

Parameters:
DIM, 128, elements per vector; power of two, >= LANES
LANES, 8, elements per input beat; power of two
DATA_W, 16, signed element width (8 or 16)
(derived) LOG2_DIM = log2(DIM); BEATS = DIM/LANES; SUM_W = DATA_W+LOG2_DIM; SQ_W = 2*DATA_W+LOG2_DIM; NUM_W = 2*DATA_W+2*LOG2_DIM+1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  block accepts a beat
in_data  in  LANES*DATA_W  packed signed elements, lane 0 in LSBs
in_last  in  1  producer's end-of-vector marker (checked only)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_mean  out  DATA_W  signed floor(sum/DIM)
out_var  out  2*DATA_W  unsigned floor((DIM*sumsq - sum^2)/DIM^2)
out_err  out  1  in_last mismatch seen in this vector

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state=ACC, beat_cnt=0, sum=0, sumsq=0, err=0, out_valid=0, out_mean=0, out_var=0, out_err=0. in_ready=0 while rst_n low.
- FSM states: ACC -> SQR -> FIN -> OUT -> ACC.
- ACC:
  - in_ready=1.
  - On handshake: add lane_reduce outputs to sum (SUM_W signed) and sumsq (SQ_W unsigned). Accumulation is exact; overflow is impossible by width choice.
  - On beat_cnt==0 the accumulators load instead of add.
  - err |= (in_last != (beat_cnt==BEATS-1)).
  - beat_cnt increments on each handshake. At beat_cnt==BEATS-1 it wraps to 0 and the state goes to SQR.
  - beat_cnt is authoritative: an early in_last does not end the vector, and a missing in_last does not extend it.
  - in_valid low inserts bubbles; no state change.
- SQR: register sum*sum (signed multiply, NUM_W) and DIM*sumsq (left shift); in_ready=0.
- FIN:
  - num = DIM*sumsq - sum^2, which is always >= 0.
  - out_var <= num >> (2*LOG2_DIM).
  - out_mean <= sum >>> LOG2_DIM (arithmetic shift, floor toward -inf).
  - out_err <= err; out_valid <= 1.
- Latency: out_valid is high 2 clocks after the clock edge that accepts the last beat.
- OUT:
  - out_valid=1, in_ready=0.
  - out_mean, out_var and out_err are held stable until out_ready.
  - On out_ready: out_valid <= 0, err <= 0, state -> ACC, so in_ready is 1 the next cycle.
- Throughput: BEATS+3 cycles per vector with out_ready tied high.
- Reset asserted mid-vector or mid-result: all state clears immediately and any partial vector is discarded. After deassertion the next accepted beat is treated as beat 0.
- out_var range: at most 2^(2*DATA_W-2), so it always fits in 2*DATA_W bits.

Decomposition:
- Package ln_stats_pkg holds:
  - the width functions (SUM_W, SQ_W, NUM_W from DIM/DATA_W);
  - the state enum {ACC, SQR, FIN, OUT};
  - a clog2-based BEATS/counter width localparam.
- One sub-module, ln_lane_reduce: combinational adder tree over LANES signed inputs giving lane_sum (DATA_W+log2(LANES) signed) and lane_sumsq (2*DATA_W+log2(LANES) unsigned). Parameterised by LANES and DATA_W.

Test Plan:
- DIM=128, LANES=8, DATA_W=16, all elements 5, in_last on beat 15 -> out_mean=5, out_var=0, out_err=0; out_valid 2 cycles after the last handshake.
- Elements alternate +3/-3 -> out_mean=0, out_var=9.
- Ramp 0..127 (sum 8128, sumsq 690880) -> out_mean=63, out_var=1365.
- 64 x -32768 then 64 x 32767 -> out_mean=-1, out_var=1073709056. Also all -32768 -> out_mean=-32768, out_var=0.
- Backpressure and bubbles:
  - random in_valid gaps -> results unchanged;
  - out_ready low for 10 cycles -> outputs stable, in_ready=0;
  - two vectors back-to-back -> each result correct, with no carry-over of sum or err.
- Two fault cases:
  - in_last asserted on beat 7 and absent on beat 15 -> result computed over 16 beats, out_err=1; next clean vector gives out_err=0.
  - rst_n pulsed low at beat 9 -> out_valid stays 0, a fresh vector then gives the correct result.
